// File: rtl/pipeline_trace_writer.sv
// Shadow IF/ID/EX/MEM/WB pipeline that follows the core's stage enables and flushes.
// It emits one retirement record per instruction leaving WB through a FWFT FIFO.
module pipeline_trace_writer #(
  parameter int DataSize  = 64,
  parameter int FifoDepth = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                if_valid,
  input  logic [DataSize-1:0] if_pc,
  input  logic [31:0]         if_inst,
  input  logic                if_id_en,
  input  logic                id_ex_en,
  input  logic                ex_mem_en,
  input  logic                mem_wb_en,
  input  logic                flush_id,
  input  logic                flush_ex,
  input  logic [4:0]          wb_rd,
  input  logic                wb_reg_we,
  input  logic [DataSize-1:0] wb_rd_data,
  input  logic                trace_ready,
  output logic                trace_valid,
  output logic [DataSize-1:0] trace_pc,
  output logic [31:0]         trace_inst,
  output logic [4:0]          trace_rd,
  output logic                trace_reg_we,
  output logic [DataSize-1:0] trace_rd_data,
  output logic                overflow,
  output logic [63:0]         retired_count
);

  localparam int AW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int RW = 2 * DataSize + 38;
  localparam logic [AW:0] FullCnt = (AW + 1)'(FifoDepth);

  logic                id_valid, ex_valid, mem_valid, wbs_valid, wb_new;
  logic [DataSize-1:0] id_pc, ex_pc, mem_pc, wbs_pc;
  logic [31:0]         id_inst, ex_inst, mem_inst, wbs_inst;

  logic [RW-1:0] fifo_mem [FifoDepth];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          commit, full, push, pop;

  logic [DataSize-1:0] head_pc, head_data;
  logic [31:0]         head_inst;
  logic [4:0]          head_rd;
  logic                head_we;

  // Flush is applied after the load so it overrides the enable on the same edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      id_valid  <= 1'b0;
      ex_valid  <= 1'b0;
      mem_valid <= 1'b0;
      wbs_valid <= 1'b0;
      wb_new    <= 1'b0;
    end else begin
      if (if_id_en) begin
        id_valid <= if_valid;
        id_pc    <= if_pc;
        id_inst  <= if_inst;
      end
      if (flush_id) id_valid <= 1'b0;
      if (id_ex_en) begin
        ex_valid <= id_valid;
        ex_pc    <= id_pc;
        ex_inst  <= id_inst;
      end
      if (flush_ex) ex_valid <= 1'b0;
      if (ex_mem_en) begin
        mem_valid <= ex_valid;
        mem_pc    <= ex_pc;
        mem_inst  <= ex_inst;
      end
      if (mem_wb_en) begin
        wbs_valid <= mem_valid;
        wbs_pc    <= mem_pc;
        wbs_inst  <= mem_inst;
      end
      wb_new <= mem_wb_en & mem_valid;
    end
  end

  // wb_new keeps a held WB entry from committing more than once.
  assign commit      = wbs_valid & wb_new;
  assign trace_valid = (count != '0);
  assign full        = (count == FullCnt);
  assign pop         = trace_valid & trace_ready;
  assign push        = commit & (~full | pop);

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= {wbs_pc, wbs_inst, wb_rd, wb_reg_we, wb_rd_data};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      overflow      <= 1'b0;
      retired_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (commit) retired_count <= retired_count + 64'd1;
      if (commit && full && !pop) overflow <= 1'b1;
    end
  end

  assign {head_pc, head_inst, head_rd, head_we, head_data} = fifo_mem[rd_ptr];

  // Stale storage is never exposed: outputs read as zero while the FIFO is empty.
  assign trace_pc      = trace_valid ? head_pc   : '0;
  assign trace_inst    = trace_valid ? head_inst : '0;
  assign trace_rd      = trace_valid ? head_rd   : '0;
  assign trace_reg_we  = trace_valid & head_we;
  assign trace_rd_data = trace_valid ? head_data : '0;

endmodule

// File: tb/tb_pipeline_trace_writer.sv
// Directed bench for pipeline_trace_writer: expected records queue up as
// instructions are issued and a negedge monitor compares every accepted record.
module tb_pipeline_trace_writer;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        we;
    logic [63:0] data;
  } rec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        if_valid = 1'b0;
  logic [63:0] if_pc = '0;
  logic [31:0] if_inst = '0;
  logic        if_id_en = 1'b1, id_ex_en = 1'b1, ex_mem_en = 1'b1, mem_wb_en = 1'b1;
  logic        flush_id = 1'b0, flush_ex = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic        wb_reg_we = 1'b0;
  logic [63:0] wb_rd_data = '0;
  logic        trace_ready = 1'b1;
  logic        trace_valid;
  logic [63:0] trace_pc;
  logic [31:0] trace_inst;
  logic [4:0]  trace_rd;
  logic        trace_reg_we;
  logic [63:0] trace_rd_data;
  logic        overflow;
  logic [63:0] retired_count;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  rec_t sb[$];
  logic [69:0] sched[int];

  pipeline_trace_writer #(.DataSize(64), .FifoDepth(4)) dut (
    .clock(clock), .reset(reset),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .flush_id(flush_id), .flush_ex(flush_ex),
    .wb_rd(wb_rd), .wb_reg_we(wb_reg_we), .wb_rd_data(wb_rd_data),
    .trace_ready(trace_ready), .trace_valid(trace_valid),
    .trace_pc(trace_pc), .trace_inst(trace_inst), .trace_rd(trace_rd),
    .trace_reg_we(trace_reg_we), .trace_rd_data(trace_rd_data),
    .overflow(overflow), .retired_count(retired_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every record accepted by the consumer must match the scoreboard head.
  always @(negedge clock) begin
    if (reset === 1'b1 && trace_valid === 1'b1 && trace_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_record: got pc %0h with no record expected", trace_pc);
      end else begin
        rec_t exp_r, act_r;
        exp_r = sb.pop_front();
        act_r = '{trace_pc, trace_inst, trace_rd, trace_reg_we, trace_rd_data};
        if (act_r !== exp_r) begin
          errors++;
          $display("FAIL record: got %h expected %h", act_r, exp_r);
        end
      end
    end
  end

  // Advance one edge; wb_* carry the values scheduled for the commit cycle, junk otherwise.
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    if (sched.exists(cyc)) {wb_rd, wb_reg_we, wb_rd_data} = sched[cyc];
    else begin
      wb_rd      = 5'h1f;
      wb_reg_we  = 1'b0;
      wb_rd_data = 64'hBAD0_BAD0_BAD0_BAD0;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // With enables high, an instruction presented now commits in the cycle after edge cyc+4.
  task automatic issue(input logic [63:0] pc, input logic [31:0] inst, input logic [4:0] rd,
                       input logic we, input logic [63:0] data, input bit expect_push);
    if_valid = 1'b1;
    if_pc    = pc;
    if_inst  = inst;
    sched[cyc + 4] = {rd, we, data};
    if (expect_push) sb.push_back('{pc, inst, rd, we, data});
    step();
    if_valid = 1'b0;
    if_pc    = 64'hDEAD;
    if_inst  = 32'hDEAD;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    steps(2);
    reset = 1'b1;
    sb.delete();
    sched.delete();
  endtask

  initial begin
    // Reset with random inputs
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      if_valid    = 1'($urandom);
      if_pc       = {$urandom, $urandom};
      if_inst     = $urandom;
      flush_id    = 1'($urandom);
      flush_ex    = 1'($urandom);
      trace_ready = 1'($urandom);
      wb_rd_data  = {$urandom, $urandom};
    end
    step();
    chk("reset_trace_valid", 64'(trace_valid), 64'd0);
    chk("reset_trace_pc", trace_pc, 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    chk("reset_retired", retired_count, 64'd0);
    if_valid = 1'b0; flush_id = 1'b0; flush_ex = 1'b0; trace_ready = 1'b1;
    reset = 1'b1;
    sb.delete();

    // Single instruction: 5 edges from IF to trace_valid
    issue(64'h1000, 32'h0050_0093, 5'd1, 1'b1, 64'd5, 1'b1);
    steps(3);
    chk("single_not_yet_valid", 64'(trace_valid), 64'd0);
    step();
    chk("single_valid", 64'(trace_valid), 64'd1);
    chk("single_pc", trace_pc, 64'h1000);
    chk("single_retired", retired_count, 64'd1);
    step();
    chk("single_drained", 64'(trace_valid), 64'd0);
    chk("single_sb_empty", 64'(sb.size()), 64'd0);

    // Flush in EX kills the instruction
    do_reset();
    issue(64'h2000, 32'h0000_0013, 5'd2, 1'b1, 64'h22, 1'b0);
    flush_ex = 1'b1;
    step();
    flush_ex = 1'b0;
    steps(8);
    chk("flush_retired", retired_count, 64'd0);
    chk("flush_no_valid", 64'(trace_valid), 64'd0);

    // WB held for 3 cycles produces a single record
    do_reset();
    issue(64'h3000, 32'h0010_0113, 5'd2, 1'b1, 64'h77, 1'b1);
    steps(3);
    mem_wb_en = 1'b0;
    steps(3);
    mem_wb_en = 1'b1;
    steps(4);
    chk("hold_retired", retired_count, 64'd1);
    chk("hold_sb_empty", 64'(sb.size()), 64'd0);

    // Backpressure: 5 back-to-back instructions into a 4-deep FIFO
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      issue(64'(4 * i), 32'h100 + 32'(i), 5'(i + 3), 1'(i % 2), 64'h50 + 64'(i), i < 4);
    steps(6);
    chk("bp_retired", retired_count, 64'd5);
    chk("bp_overflow", 64'(overflow), 64'd1);
    chk("bp_valid", 64'(trace_valid), 64'd1);
    chk("bp_head_pc", trace_pc, 64'h0);
    step();
    chk("bp_head_stable", trace_pc, 64'h0);
    trace_ready = 1'b1;
    steps(4);
    chk("bp_drained", 64'(trace_valid), 64'd0);
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);
    chk("bp_overflow_sticky", 64'(overflow), 64'd1);

    // Full FIFO with a pop on the same edge as a commit: no drop
    do_reset();
    chk("reset_clears_overflow", 64'(overflow), 64'd0);
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      issue(64'h4000 + 64'(4 * i), 32'h200 + 32'(i), 5'(i + 10), 1'b1, 64'h90 + 64'(i), 1'b1);
    steps(3);
    trace_ready = 1'b1;
    step();
    trace_ready = 1'b0;
    chk("pp_overflow", 64'(overflow), 64'd0);
    chk("pp_retired", retired_count, 64'd5);
    chk("pp_head_pc", trace_pc, 64'h4004);
    trace_ready = 1'b1;
    steps(3);
    trace_ready = 1'b0;
    chk("pp_occupancy_last", 64'(trace_valid), 64'd1);
    chk("pp_last_pc", trace_pc, 64'h4010);

    // Reset mid-stream discards FIFO contents
    reset = 1'b0;
    step();
    chk("midreset_valid", 64'(trace_valid), 64'd0);
    chk("midreset_pc", trace_pc, 64'd0);
    chk("midreset_retired", retired_count, 64'd0);
    reset = 1'b1;
    sb.delete();
    trace_ready = 1'b1;
    steps(3);
    chk("midreset_stays_empty", 64'(trace_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_trace_writer.md
# pipeline_trace_writer

Shadow pipeline that mirrors the five-stage dataflow (IF/ID/EX/MEM/WB) and emits one retirement record per instruction leaving WB. It sits beside the core dataflow. It consumes the same stage-register enables and flushes that the hazard unit drives, and it produces the per-stage snapshot stream that dataflow testbenches and debug logic read. Records are buffered in a small FIFO with a valid/ready handshake. Overflow is flagged, never stalls the core.

## Interface
Parameters:
- DataSize, 64, datapath/PC width
- FifoDepth, 4, trace FIFO entries (power of two, ≥2)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- if_valid  in  1  IF stage holds a real instruction
- if_pc  in  DataSize  IF stage PC
- if_inst  in  32  IF stage instruction word
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  in  1 each  stage-register load enables
- flush_id, flush_ex  in  1 each  bubble insertion into ID / EX
- wb_rd  in  5  WB destination register
- wb_reg_we  in  1  WB register write enable
- wb_rd_data  in  DataSize  WB write-back data
- trace_ready  in  1  consumer accepts head record
- trace_valid  out  1  head record available
- trace_pc  out  DataSize  record PC
- trace_inst  out  32  record instruction
- trace_rd  out  5  record rd
- trace_reg_we  out  1  record write enable
- trace_rd_data  out  DataSize  record write data
- overflow  out  1  sticky: a record was dropped
- retired_count  out  64  records generated (pushed + dropped)

## Operation
- Shadow stages ID, EX, MEM, WB each hold {valid, pc, inst}.
- ID loads {if_valid, if_pc, if_inst} when if_id_en. EX loads from ID when id_ex_en. MEM loads from EX when ex_mem_en. WB loads from MEM when mem_wb_en. A stage holds when its enable is low.
- flush_id clears ID.valid and flush_ex clears EX.valid on that edge. Flush wins over enable; pc/inst are don't-care.
- wb_new: register set on any edge where mem_wb_en=1, taking the value of MEM.valid; cleared otherwise. This makes a held WB entry produce exactly one record.
- Commit event: WB.valid & wb_new during a cycle. The record is {WB.pc, WB.inst, wb_rd, wb_reg_we, wb_rd_data}, sampled at the edge ending that cycle.
- On a commit event:
  - retired_count increments by 1, wrapping mod 2^64.
  - If the FIFO is not full, or a pop happens on the same edge, the record is pushed.
  - Otherwise the record is dropped and overflow is set.
- FIFO is FWFT. trace_* outputs show the head entry. A pop occurs on an edge where trace_valid & trace_ready.
- Push and pop on the same edge:
  - Allowed in every state, including full.
  - Occupancy is unchanged; the head advances.
  - Empty + push + ready gives no pop, because trace_valid was 0.
- trace_* outputs are 0 whenever trace_valid=0.
- overflow clears only on reset.
- Duplicated or missing instructions caused by inconsistent enables are the driver's responsibility. The block mirrors enables literally.

## Timing
- Reset (reset=0 at an edge):
  - All shadow valids, wb_new, FIFO pointers and count, overflow, retired_count go to 0.
  - trace_valid and all trace_* are 0 from the following cycle.
  - This applies mid-operation too: FIFO contents are discarded and in-flight shadow instructions are lost.
- Latency with all enables high and no flush:
  - IF inputs are sampled at edge 1 and reach WB at edge 4.
  - The commit cycle is between edges 4 and 5; the wb_* inputs must be valid in that cycle.
  - trace_valid rises after edge 5. Total is 5 edges IF→trace.
- Throughput is one record per cycle sustained when trace_ready=1.
- trace_valid stays high and trace_* stay stable until accepted. Data only changes after a pop edge.
- retired_count and overflow update at the same edge as the push/drop decision.

## Test plan
- Reset: hold reset=0 for 2 cycles with random inputs → trace_valid=0, trace_pc=0, overflow=0, retired_count=0.
- Single instruction:
  - Stimulus: if_pc=0x1000, if_inst=0x00500093, enables=1. During the commit cycle drive wb_rd=1, wb_reg_we=1, wb_rd_data=5.
  - Response: trace_valid=1 after edge 5 with exactly those values; retired_count=1.
- Flush: assert flush_ex on the edge the instruction moves ID→EX → no record ever emitted; retired_count stays 0.
- WB hold: mem_wb_en=0 for 3 cycles while WB.valid=1 → exactly one record; retired_count=1.
- Backpressure:
  - Stimulus: trace_ready=0, 5 back-to-back instructions at pc 0x0,0x4,…,0x10, FifoDepth=4.
  - Response: 4 records buffered, overflow=1, retired_count=5.
  - Then trace_ready=1 → records 0x0,0x4,0x8,0xC in order, one per cycle, then trace_valid=0.
- Full push+pop: FIFO full, trace_ready=1 on the same edge as a commit → no drop, overflow stays 0, occupancy stays 4. Then apply reset=0 mid-stream → FIFO empty and trace_valid=0 the next cycle.
